// File: rtl/instruction_mem_sync_if.sv
// Loader and fetch signals between the IF stage and the synchronous instruction memory.
// The memory uses the slave modport; the loader/fetch side uses master.
interface instruction_mem_sync_if #(
  parameter int unsigned WORD_W = 32
);
  logic              Load_Valid;
  logic [WORD_W-1:0] Load_Data;
  logic              Load_Last;
  logic              Load_Ready;
  logic              Reload;
  logic [31:0]       PC;
  logic              Stall;
  logic              Flush;
  logic [WORD_W-1:0] Instruction;
  logic              Inst_Valid;
  logic              Addr_Error;

  modport master (
    output Load_Valid, Load_Data, Load_Last, Reload, PC, Stall, Flush,
    input  Load_Ready, Instruction, Inst_Valid, Addr_Error
  );

  modport slave (
    input  Load_Valid, Load_Data, Load_Last, Reload, PC, Stall, Flush,
    output Load_Ready, Instruction, Inst_Valid, Addr_Error
  );
endinterface

// File: rtl/instruction_mem_sync.sv
// Synchronous instruction memory: word-by-word loader (LOAD), then registered fetch
// with stall/flush and NOP substitution for unloaded or out-of-range addresses (RUN).
module instruction_mem_sync #(
  parameter int unsigned       ADDR_BITS = 3,
  parameter int unsigned       WORD_W    = 32,
  parameter logic [WORD_W-1:0] NOP       = '0
) (
  input logic                   clk,
  input logic                   rst,
  instruction_mem_sync_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]           state;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS:0]   load_count;
  logic [WORD_W-1:0]    mem [DEPTH];

  logic                 beat;
  logic [ADDR_BITS-1:0] idx;
  logic                 in_range;
  logic                 misaligned;

  assign bus.Load_Ready = (state == S_LOAD);
  assign beat           = bus.Load_Valid & bus.Load_Ready;

  assign idx        = bus.PC[ADDR_BITS+1:2];
  assign in_range   = (bus.PC[31:ADDR_BITS+2] == '0) && ({1'b0, idx} < load_count);
  assign misaligned = (bus.PC[1:0] != 2'b00);

  // Storage is deliberately not reset; load_count masks anything not yet loaded.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_ptr] <= bus.Load_Data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      load_count <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (beat) begin
            wr_ptr     <= wr_ptr + 1'b1;
            load_count <= {1'b0, wr_ptr} + 1'b1;
            if (bus.Load_Last || (wr_ptr == '1)) begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.Reload) begin
            state      <= S_LOAD;
            wr_ptr     <= '0;
            load_count <= '0;
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

  // Reload outranks Flush and Stall; LOAD forces a bubble regardless of PC.
  always_ff @(posedge clk) begin
    if (rst || (state != S_RUN) || bus.Reload || bus.Flush) begin
      bus.Instruction <= NOP;
      bus.Inst_Valid  <= 1'b0;
      bus.Addr_Error  <= 1'b0;
    end else if (!bus.Stall) begin
      if (in_range && !misaligned) begin
        bus.Instruction <= mem[idx];
        bus.Inst_Valid  <= 1'b1;
        bus.Addr_Error  <= 1'b0;
      end else begin
        bus.Instruction <= NOP;
        bus.Inst_Valid  <= 1'b0;
        bus.Addr_Error  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/instruction_mem_sync.md
# instruction_mem_sync

Parametrised, synchronous instruction memory for the IF stage of the pipeline. It replaces the fixed 8-word combinational ROM with several additions:
- a loader port that fills the memory word-by-word over a valid/ready handshake;
- a registered fetch output with stall and flush control;
- NOP substitution for unloaded or out-of-range addresses.

Fetch is enabled only after a program has been loaded.

## Interface
Parameters:
- ADDR_BITS, 3, word-address width; DEPTH = 2**ADDR_BITS words.
- WORD_W, 32, instruction width.
- NOP, 0 (WORD_W bits), word driven for flushed, unloaded or out-of-range fetches.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- Load_Valid  input  1  loader word present.
- Load_Data  input  WORD_W  loader word.
- Load_Last  input  1  marks final word of program (qualified by Load_Valid).
- Load_Ready  output  1  memory accepts a loader word this cycle.
- Reload  input  1  in RUN, return to LOAD and discard program.
- PC  input  32  byte address of fetch.
- Stall  input  1  hold fetch output.
- Flush  input  1  replace fetch output with bubble.
- Instruction  output  WORD_W  fetched word (registered).
- Inst_Valid  output  1  Instruction is a real fetched word.
- Addr_Error  output  1  registered flag: last fetch was misaligned or out of range.

## Operation
- States: LOAD, RUN. Reset state LOAD.
- LOAD:
  - Load_Ready=1.
  - A beat (Load_Valid & Load_Ready) writes Load_Data to mem[wr_ptr], increments wr_ptr and sets Load_Count = wr_ptr+1.
  - LOAD→RUN after a beat with Load_Last=1, or after the beat at wr_ptr=DEPTH-1 (memory full; no wrap).
  - While in LOAD, PC/Stall/Flush are ignored: Instruction=NOP, Inst_Valid=0, Addr_Error=0.
- RUN:
  - Load_Ready=0. Load_Valid is ignored and nothing is written.
  - Reload=1 → LOAD next cycle with wr_ptr=0 and Load_Count=0. Memory contents are not cleared. Output goes to NOP/invalid on that edge.
- Fetch in RUN, on each edge, with priority Flush > Stall > fetch:
  - Flush: Instruction←NOP, Inst_Valid←0, Addr_Error←0.
  - Stall, no Flush: all outputs hold.
  - Otherwise, with idx = PC[ADDR_BITS+1:2]:
    - in_range = (PC[31:ADDR_BITS+2]==0) & (idx < Load_Count).
    - misaligned = PC[1:0]≠0.
    - If in_range & !misaligned: Instruction←mem[idx], Inst_Valid←1, Addr_Error←0.
    - Else: Instruction←NOP, Inst_Valid←0, Addr_Error←1.
- Load_Count is ADDR_BITS+1 wide (range 0..DEPTH). Unloaded locations read as NOP, never as stale memory.
- Reset values: state=LOAD, wr_ptr=0, Load_Count=0, Instruction=NOP, Inst_Valid=0, Addr_Error=0, Load_Ready=1 (combinational from state). Memory array is not reset.
- rst has priority over every other input. A reset asserted mid-load discards the partial program; the count returns to 0.

## Timing
- Load_Ready is combinational from state only, with no dependence on Load_Valid.
- Loader: one word per cycle. The RUN transition is visible the cycle after the last beat.
- Fetch latency: 1 cycle. PC presented in cycle n produces Instruction/Inst_Valid/Addr_Error valid after edge n+1.
- The first fetch is possible in the first RUN cycle. The output reflects it one edge later.
- A Reload issued in the same cycle as Flush or Stall: Reload wins. Outputs go to NOP/0.
- Write and read never coincide, because the states are exclusive. No read-during-write rule is needed.

## Test plan
- Reset, then load 3 words (0x11,0x22,0x33; Last on 3rd): Load_Ready falls the cycle after beat 3. PC=0,4,8 on consecutive cycles → Instruction=0x11,0x22,0x33 one cycle later, Inst_Valid=1.
- With ADDR_BITS=3 and 3 words loaded: PC=12 → NOP, Inst_Valid=0, Addr_Error=1. PC=0x20 → NOP, Addr_Error=1. PC=5 → NOP, Addr_Error=1.
- Load 8 words without Load_Last: after the 8th beat, state is RUN and a 9th Load_Valid beat is ignored. PC=28 → the 8th word.
- In RUN, fetch PC=4, then Stall for 3 cycles with PC changing: Instruction holds word 1. Assert Flush together with Stall: Instruction=NOP and Inst_Valid=0 next cycle.
- Assert rst after 2 load beats: Load_Count=0 and Load_Ready=1. Reload then 1 word 0xAB with Last: PC=0 → 0xAB, and PC=4 → NOP with Addr_Error=1 (old contents not visible).
- Hold Load_Valid high with Last for 2 cycles in LOAD: only the first word is written. The second is ignored because Load_Ready=0.
